// File: rtl/ysyx_24070014_key_demux.sv
// Key-routed 1-to-NR_PORT request demultiplexer with a single outstanding transaction and a response return path.
// Optional request/response watchdog is enabled by defining KEY_DEMUX_TIMEOUT_EN.
module ysyx_24070014_key_demux #(
    parameter int unsigned NR_PORT     = 2,
    parameter int unsigned KEY_LEN     = 1,
    parameter int unsigned DATA_LEN    = 1,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NR_PORT*KEY_LEN-1:0]   key_lut,
    input  logic                         up_req_valid,
    output logic                         up_req_ready,
    input  logic [KEY_LEN-1:0]           up_req_key,
    input  logic [DATA_LEN-1:0]          up_req_data,
    output logic                         up_rsp_valid,
    input  logic                         up_rsp_ready,
    output logic [DATA_LEN-1:0]          up_rsp_data,
    output logic                         up_rsp_err,
    output logic [NR_PORT-1:0]           dn_req_valid,
    input  logic [NR_PORT-1:0]           dn_req_ready,
    output logic [KEY_LEN-1:0]           dn_req_key,
    output logic [DATA_LEN-1:0]          dn_req_data,
    input  logic [NR_PORT-1:0]           dn_rsp_valid,
    output logic [NR_PORT-1:0]           dn_rsp_ready,
    input  logic [NR_PORT*DATA_LEN-1:0]  dn_rsp_data,
    input  logic [NR_PORT-1:0]           dn_rsp_err
);

    localparam int unsigned SEL_W = (NR_PORT > 1) ? $clog2(NR_PORT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    if ((NR_PORT < 1) || (TIMEOUT_CYC < 1)) begin : g_bad_cfg
        $error("key_demux: NR_PORT and TIMEOUT_CYC must both be at least 1");
    end

    function automatic logic [NR_PORT-1:0] f_onehot(input logic [SEL_W-1:0] sel);
        logic [NR_PORT-1:0] v;
        for (int i = 0; i < NR_PORT; i++) begin
            v[i] = (SEL_W'(i) == sel);
        end
        return v;
    endfunction

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SEL_W-1:0]      r_sel;
    logic [SEL_W-1:0]      w_sel_nxt;
    logic [KEY_LEN-1:0]    r_key;
    logic [KEY_LEN-1:0]    w_key_nxt;
    logic [DATA_LEN-1:0]   r_data;
    logic [DATA_LEN-1:0]   w_data_nxt;
    logic [DATA_LEN-1:0]   r_rsp_data;
    logic [DATA_LEN-1:0]   w_rsp_data_nxt;
    logic                  r_rsp_err;
    logic                  w_rsp_err_nxt;
    logic                  r_up_req_ready;
    logic                  r_up_rsp_valid;
    logic [NR_PORT-1:0]    r_dn_req_valid;
    logic [NR_PORT-1:0]    r_dn_rsp_ready;
    logic                  w_hit;
    logic [SEL_W-1:0]      w_hit_idx;
    logic                  w_expire;

`ifdef KEY_DEMUX_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] r_cnt;

    assign w_expire = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Watchdog: zero while idle (so it is clear on REQ entry), counts every REQ/WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= '0;
        end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    // Key lookup: scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = NR_PORT - 1; i >= 0; i--) begin
            w_hit_idx = (key_lut[i*KEY_LEN +: KEY_LEN] == up_req_key) ? SEL_W'(i) : w_hit_idx;
            w_hit     = w_hit | (key_lut[i*KEY_LEN +: KEY_LEN] == up_req_key);
        end
    end

    // Next-state and captured-value logic for the transaction FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_key_nxt      = r_key;
        w_data_nxt     = r_data;
        w_rsp_data_nxt = r_rsp_data;
        w_rsp_err_nxt  = r_rsp_err;
        case (r_state)
            S_IDLE: begin
                if (up_req_valid && r_up_req_ready) begin
                    w_key_nxt  = up_req_key;
                    w_data_nxt = up_req_data;
                    if (w_hit) begin
                        w_sel_nxt   = w_hit_idx;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_rsp_data_nxt = '0;
                        w_rsp_err_nxt  = 1'b1;
                        w_state_nxt    = S_RESP;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_REQ: begin
                // A handshake on the expiry cycle takes priority over the abort.
                if (dn_req_ready[r_sel]) begin
                    w_state_nxt = S_WAIT;
                end else if (w_expire) begin
                    w_rsp_data_nxt = '0;
                    w_rsp_err_nxt  = 1'b1;
                    w_state_nxt    = S_RESP;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_WAIT: begin
                if (dn_rsp_valid[r_sel]) begin
                    w_rsp_data_nxt = dn_rsp_data[r_sel*DATA_LEN +: DATA_LEN];
                    w_rsp_err_nxt  = dn_rsp_err[r_sel];
                    w_state_nxt    = S_RESP;
                end else if (w_expire) begin
                    w_rsp_data_nxt = '0;
                    w_rsp_err_nxt  = 1'b1;
                    w_state_nxt    = S_RESP;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_RESP: begin
                if (up_rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, captured fields and handshake outputs, all decoded from the next state so they leave flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_sel          <= '0;
            r_key          <= '0;
            r_data         <= '0;
            r_rsp_data     <= '0;
            r_rsp_err      <= 1'b0;
            r_up_req_ready <= 1'b0;
            r_up_rsp_valid <= 1'b0;
            r_dn_req_valid <= '0;
            r_dn_rsp_ready <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_sel          <= w_sel_nxt;
            r_key          <= w_key_nxt;
            r_data         <= w_data_nxt;
            r_rsp_data     <= w_rsp_data_nxt;
            r_rsp_err      <= w_rsp_err_nxt;
            r_up_req_ready <= (w_state_nxt == S_IDLE);
            r_up_rsp_valid <= (w_state_nxt == S_RESP);
            r_dn_req_valid <= (w_state_nxt == S_REQ)  ? f_onehot(w_sel_nxt) : '0;
            r_dn_rsp_ready <= (w_state_nxt == S_WAIT) ? f_onehot(w_sel_nxt) : '0;
        end
    end

    assign up_req_ready = r_up_req_ready;
    assign up_rsp_valid = r_up_rsp_valid;
    assign up_rsp_data  = r_rsp_data;
    assign up_rsp_err   = r_rsp_err;
    assign dn_req_valid = r_dn_req_valid;
    assign dn_rsp_ready = r_dn_rsp_ready;
    assign dn_req_key   = r_key;
    assign dn_req_data  = r_data;

endmodule

// File: tb/tb_ysyx_24070014_key_demux.sv
// Scoreboard bench for ysyx_24070014_key_demux (NR_PORT=4, KEY_LEN=2, DATA_LEN=8, TIMEOUT_CYC=8).
// Expected responses are queued by the stimulus and consumed by an independent monitor.
module tb_ysyx_24070014_key_demux;

    localparam int NR = 4;
    localparam int KL = 2;
    localparam int DL = 8;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR*KL-1:0] key_lut;
    logic            up_req_valid;
    logic            up_req_ready;
    logic [KL-1:0]   up_req_key;
    logic [DL-1:0]   up_req_data;
    logic            up_rsp_valid;
    logic            up_rsp_ready;
    logic [DL-1:0]   up_rsp_data;
    logic            up_rsp_err;
    logic [NR-1:0]   dn_req_valid;
    logic [NR-1:0]   dn_req_ready;
    logic [KL-1:0]   dn_req_key;
    logic [DL-1:0]   dn_req_data;
    logic [NR-1:0]   dn_rsp_valid;
    logic [NR-1:0]   dn_rsp_ready;
    logic [NR*DL-1:0] dn_rsp_data;
    logic [NR-1:0]   dn_rsp_err;

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    ysyx_24070014_key_demux #(
        .NR_PORT(NR), .KEY_LEN(KL), .DATA_LEN(DL), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .key_lut(key_lut),
        .up_req_valid(up_req_valid), .up_req_ready(up_req_ready),
        .up_req_key(up_req_key), .up_req_data(up_req_data),
        .up_rsp_valid(up_rsp_valid), .up_rsp_ready(up_rsp_ready),
        .up_rsp_data(up_rsp_data), .up_rsp_err(up_rsp_err),
        .dn_req_valid(dn_req_valid), .dn_req_ready(dn_req_ready),
        .dn_req_key(dn_req_key), .dn_req_data(dn_req_data),
        .dn_rsp_valid(dn_rsp_valid), .dn_rsp_ready(dn_rsp_ready),
        .dn_rsp_data(dn_rsp_data), .dn_rsp_err(dn_rsp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and return right after the accepting edge.
    task automatic do_req(input logic [KL-1:0] k, input logic [DL-1:0] d);
        int n;
        n = 0;
        up_req_valid = 1'b1;
        up_req_key   = k;
        up_req_data  = d;
        while (!up_req_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("req_accept_timeout", 32'd0, 32'd1);
        tick();
        up_req_valid = 1'b0;
    endtask

    // Run until the upstream response handshake edge has passed.
    task automatic wait_rsp(input int bound);
        int n;
        n = 0;
        while (!(up_rsp_valid && up_rsp_ready) && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) chk("rsp_timeout", 32'd0, 32'd1);
        else tick();
    endtask

    // Monitor: every upstream response transfer must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && up_rsp_valid && up_rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", {23'd0, up_rsp_err, up_rsp_data}, 32'h1FF);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("rsp_data", {24'd0, up_rsp_data}, {24'd0, e[7:0]});
                chk("rsp_err", {31'd0, up_rsp_err}, {31'd0, e[8]});
            end
        end
    end

    initial begin
        int n;
        rst          = 1'b1;
        up_req_valid = 1'b0;
        up_req_key   = '0;
        up_req_data  = '0;
        up_rsp_ready = 1'b0;
        key_lut      = {2'd3, 2'd2, 2'd1, 2'd0};
        dn_req_ready = 4'h0;
        dn_rsp_valid = 4'h0;
        dn_rsp_data  = {8'hDD, 8'hC3, 8'hBB, 8'hAA};
        dn_rsp_err   = 4'h0;
        tick();
        tick();
        chk("rst_up_req_ready", {31'd0, up_req_ready}, 32'd0);
        chk("rst_up_rsp_valid", {31'd0, up_rsp_valid}, 32'd0);
        chk("rst_dn_valid_ready", {24'd0, dn_req_valid, dn_rsp_ready}, 32'd0);
        chk("rst_dn_key_data", {22'd0, dn_req_key, dn_req_data}, 32'd0);
        chk("rst_rsp_data_err", {23'd0, up_rsp_err, up_rsp_data}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", {31'd0, up_req_ready}, 32'd1);

        // Test 1: key 2 routes to port 2, minimum-latency round trip.
        dn_req_ready = 4'hF;
        dn_rsp_valid = 4'b0100;
        up_rsp_ready = 1'b1;
        exp_q.push_back({1'b0, 8'hC3});
        do_req(2'd2, 8'h5A);
        chk("t1_dn_req_valid", {28'd0, dn_req_valid}, 32'h4);
        chk("t1_dn_req_key", {30'd0, dn_req_key}, 32'd2);
        chk("t1_dn_req_data", {24'd0, dn_req_data}, 32'h5A);
        chk("t1_busy_not_ready", {31'd0, up_req_ready}, 32'd0);
        n = 0;
        while (!up_rsp_valid && n < 20) begin
            tick();
            n++;
        end
        // Cycles from the accept cycle through the response-transfer cycle, inclusive.
        chk("t1_round_trip", n + 2, 32'd4);
        wait_rsp(10);

        // Test 2: duplicate keys pick the lowest index; an unknown key is a decode error.
        key_lut      = {2'd1, 2'd1, 2'd0, 2'd0};
        dn_rsp_valid = 4'b0001;
        exp_q.push_back({1'b0, 8'hAA});
        do_req(2'd0, 8'h01);
        chk("t2_dup_lowest", {28'd0, dn_req_valid}, 32'h1);
        wait_rsp(10);
        exp_q.push_back({1'b1, 8'h00});
        do_req(2'd2, 8'h02);
        chk("t2_miss_no_dn", {28'd0, dn_req_valid}, 32'h0);
        chk("t2_miss_rsp_next", {31'd0, up_rsp_valid}, 32'd1);
        wait_rsp(10);

        // Test 3: back-pressure on port 1 request and upstream response; port 0 chatter ignored.
        key_lut      = {2'd3, 2'd2, 2'd1, 2'd0};
        dn_req_ready = 4'b1101;
        dn_rsp_valid = 4'b0001;
        up_rsp_ready = 1'b0;
        do_req(2'd1, 8'h33);
        for (int i = 0; i < 6; i++) begin
            chk("t3_req_held", {28'd0, dn_req_valid}, 32'h2);
            chk("t3_port0_never_acked", {28'd0, dn_rsp_ready}, 32'h0);
            if (i == 5) dn_req_ready = 4'hF;
            tick();
        end
        chk("t3_wait_ready", {24'd0, dn_req_valid, dn_rsp_ready}, 32'h02);
        dn_rsp_valid = 4'b0011;
        exp_q.push_back({1'b0, 8'hBB});
        tick();
        dn_rsp_valid       = 4'b0001;
        dn_rsp_data[15:8]  = 8'h00;
        for (int i = 0; i < 3; i++) begin
            chk("t3_rsp_stable", {23'd0, up_rsp_valid, up_rsp_data}, 32'h1BB);
            tick();
        end
        up_rsp_ready = 1'b1;
        wait_rsp(10);
        dn_rsp_data[15:8] = 8'hBB;

        // Test 4: slave error from port 3 is passed through with its data.
        dn_rsp_valid      = 4'b1000;
        dn_rsp_err        = 4'b1000;
        dn_rsp_data[31:24] = 8'h11;
        exp_q.push_back({1'b1, 8'h11});
        do_req(2'd3, 8'h44);
        wait_rsp(10);
        dn_rsp_err = 4'h0;

        // Test 5: reset in WAIT drops the transaction; later slave response is ignored.
        dn_rsp_valid = 4'h0;
        do_req(2'd0, 8'h55);
        tick();
        chk("t5_in_wait", {28'd0, dn_rsp_ready}, 32'h1);
        rst = 1'b1;
        tick();
        chk("t5_rst_ready_valid", {30'd0, up_req_ready, up_rsp_valid}, 32'd0);
        chk("t5_rst_dn", {24'd0, dn_req_valid, dn_rsp_ready}, 32'd0);
        chk("t5_rst_key_data", {22'd0, dn_req_key, dn_req_data}, 32'd0);
        rst = 1'b0;
        dn_rsp_valid = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_no_stale_rsp", {31'd0, up_rsp_valid}, 32'd0);
        end
        dn_rsp_valid = 4'b0100;
        exp_q.push_back({1'b0, 8'hC3});
        do_req(2'd2, 8'h77);
        chk("t5_reroute", {28'd0, dn_req_valid}, 32'h4);
        wait_rsp(10);

        // Test 6: slave accepts but never responds.
        dn_rsp_valid = 4'h0;
        do_req(2'd1, 8'h66);
`ifdef KEY_DEMUX_TIMEOUT_EN
        exp_q.push_back({1'b1, 8'h00});
        n = 0;
        while (!up_rsp_valid && n < 50) begin
            tick();
            n++;
        end
        chk("t6_timeout_cycles", n, TO);
        chk("t6_dn_dropped", {24'd0, dn_req_valid, dn_rsp_ready}, 32'd0);
        wait_rsp(10);
`else
        repeat (100) tick();
        chk("t6_still_wait", {28'd0, dn_rsp_ready}, 32'h2);
        chk("t6_no_rsp", {31'd0, up_rsp_valid}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
